// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the two-screen LCD framebuffer path.
//   MODE_*       : PPU mode encodings reported on modeN.
//   FRAME_PIX_GB : pixels in one 160x144 frame.
//   PIX_W        : width of a BGR555 pixel.
package lcd_pkg;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam int FRAME_PIX_GB = 23040;
  localparam int PIX_W        = 15;

endpackage

// File: rtl/lcd_pix_fifo.sv
// lcd_pix_fifo: small show-ahead FIFO for one PPU pixel stream.
//   clk, reset : clock and asynchronous active-high reset.
//   flush      : empties the FIFO; a push in the same cycle is discarded.
//   push, din  : write request and pixel.
//   pop        : consume the head entry (ignored when empty).
//   dout       : head entry, valid whenever empty is low.
//   empty/full : occupancy flags.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module lcd_pix_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PIX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int IW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [IW:0]  wr_ptr_reg, rd_ptr_reg;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en, rd_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                 (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);

  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && !flush && (!full || rd_en);

  assign dout = mem[rd_ptr_reg[IW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[IW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_fb_write_arbiter.sv
// lcd_fb_write_arbiter: merges two PPU pixel streams into one framebuffer
// write port. Screen 0 owns words 0..FRAME_PIX-1, screen 1 owns words
// FRAME_PIX..2*FRAME_PIX-1.
//   clk, reset             : clock and asynchronous active-high reset.
//   ceN, dataN, modeN, onN : per-source pixel strobe, pixel, PPU mode, LCD on.
//   ovf_clr                : clears both sticky overflow flags.
//   fb_we, fb_addr, fb_data: registered framebuffer write port.
//   frame_done             : per-source pulse with the last write of a frame.
//   ovf                    : per-source sticky FIFO overflow.
module lcd_fb_write_arbiter
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_PIX  = FRAME_PIX_GB,
  parameter int AW         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce0,
  input  logic [PIX_W-1:0] data0,
  input  logic [1:0]       mode0,
  input  logic             on0,
  input  logic             ce1,
  input  logic [PIX_W-1:0] data1,
  input  logic [1:0]       mode1,
  input  logic             on1,
  input  logic             ovf_clr,
  output logic             fb_we,
  output logic [AW-1:0]    fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic [1:0]       frame_done,
  output logic [1:0]       ovf
);

  localparam int PTR_W = $clog2(FRAME_PIX + 1);

  logic [1:0]       ce, flush, empty, full, avail, pop, ovf_set;
  logic [PIX_W-1:0] din  [2];
  logic [PIX_W-1:0] dout [2];

  logic             grant_valid, grant_src;
  logic [PTR_W-1:0] sel_ptr;

  logic [1:0][PTR_W-1:0] ptr_reg, ptr_next;
  logic                  last_grant_reg, last_grant_next;
  logic                  fb_we_reg, fb_we_next;
  logic [AW-1:0]         fb_addr_reg, fb_addr_next;
  logic [PIX_W-1:0]      fb_data_reg, fb_data_next;
  logic [1:0]            frame_done_reg, frame_done_next;
  logic [1:0]            ovf_reg, ovf_next;

  assign ce       = {ce1, ce0};
  assign din[0]   = data0;
  assign din[1]   = data1;
  // A source is flushed whenever its LCD is off or it is in vblank.
  assign flush[0] = !on0 || (mode0 == MODE_VBLANK);
  assign flush[1] = !on1 || (mode1 == MODE_VBLANK);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      lcd_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush[gi]),
        .push  (ce[gi]),
        .din   (din[gi]),
        .pop   (pop[gi]),
        .dout  (dout[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );

      assign avail[gi]   = !empty[gi] && !flush[gi];
      assign pop[gi]     = grant_valid && (grant_src == gi[0]);
      // Dropped pixel: full, not draining this cycle, and not being flushed.
      assign ovf_set[gi] = ce[gi] && !flush[gi] && full[gi] && !pop[gi];
    end
  endgenerate

  // Round-robin: on a tie the source that did not win last time is granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = 1'b0;
    if (avail[0] && avail[1]) begin
      grant_valid = 1'b1;
      grant_src   = ~last_grant_reg;
    end else if (avail[0]) begin
      grant_valid = 1'b1;
      grant_src   = 1'b0;
    end else if (avail[1]) begin
      grant_valid = 1'b1;
      grant_src   = 1'b1;
    end
  end

  assign sel_ptr = ptr_reg[grant_src];

  always_comb begin
    fb_we_next      = 1'b0;
    frame_done_next = 2'b00;
    fb_addr_next    = fb_addr_reg;
    fb_data_next    = fb_data_reg;
    ptr_next        = ptr_reg;
    last_grant_next = last_grant_reg;
    // Set takes priority over clear.
    ovf_next        = (ovf_clr ? 2'b00 : ovf_reg) | ovf_set;

    if (flush[0]) ptr_next[0] = '0;
    if (flush[1]) ptr_next[1] = '0;

    if (grant_valid) begin
      last_grant_next = grant_src;
      // A saturated pointer means the frame is complete; the popped pixel
      // is discarded until the source is flushed at vblank.
      if (sel_ptr < PTR_W'(FRAME_PIX)) begin
        fb_we_next                 = 1'b1;
        fb_addr_next               = AW'(sel_ptr) + (grant_src ? AW'(FRAME_PIX) : '0);
        fb_data_next               = dout[grant_src];
        ptr_next[grant_src]        = sel_ptr + 1'b1;
        frame_done_next[grant_src] = (sel_ptr == PTR_W'(FRAME_PIX - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg        <= '0;
      last_grant_reg <= 1'b1;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
      frame_done_reg <= 2'b00;
      ovf_reg        <= 2'b00;
    end else begin
      ptr_reg        <= ptr_next;
      last_grant_reg <= last_grant_next;
      fb_we_reg      <= fb_we_next;
      fb_addr_reg    <= fb_addr_next;
      fb_data_reg    <= fb_data_next;
      frame_done_reg <= frame_done_next;
      ovf_reg        <= ovf_next;
    end
  end

  assign fb_we      = fb_we_reg;
  assign fb_addr    = fb_addr_reg;
  assign fb_data    = fb_data_reg;
  assign frame_done = frame_done_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_lcd_fb_write_arbiter.sv
// tb_lcd_fb_write_arbiter: directed stimulus for lcd_fb_write_arbiter with a
// queue-based reference model compared against the DUT after every edge,
// plus literal expectations at key points of each scenario.
module tb_lcd_fb_write_arbiter;

  localparam int FP    = 23040;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce0 = 1'b0, ce1 = 1'b0;
  logic [14:0] data0 = '0, data1 = '0;
  logic [1:0]  mode0 = 2'd3, mode1 = 2'd3;
  logic        on0 = 1'b1, on1 = 1'b1;
  logic        ovf_clr = 1'b0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [14:0] fb_data;
  logic [1:0]  frame_done;
  logic [1:0]  ovf;

  lcd_fb_write_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .FRAME_PIX  (FP),
    .AW         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce0        (ce0),
    .data0      (data0),
    .mode0      (mode0),
    .on0        (on0),
    .ce1        (ce1),
    .data1      (data1),
    .mode1      (mode1),
    .on1        (on1),
    .ovf_clr    (ovf_clr),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit verbose = 1'b1;
  int w0 = 0, w1 = 0;

  // Reference model state.
  logic [14:0] q0[$];
  logic [14:0] q1[$];
  int          mptr[2];
  int          mlast;
  logic [1:0]  movf;
  logic        m_we;
  logic [15:0] m_addr;
  logic [14:0] m_data;
  logic [1:0]  m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mptr[0] = 0;
    mptr[1] = 0;
    mlast   = 1;
    movf    = 2'b00;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_done  = 2'b00;
  endtask

  task automatic idle_inputs();
    ce0 = 1'b0; ce1 = 1'b0; ovf_clr = 1'b0;
    on0 = 1'b1; on1 = 1'b1; mode0 = 2'd3; mode1 = 2'd3;
  endtask

  // Computes what the outputs must be after the coming edge.
  task automatic model_cycle();
    bit fl0, fl1, av0, av1;
    int g;
    logic [14:0] px;
    fl0 = !on0 || (mode0 == 2'd1);
    fl1 = !on1 || (mode1 == 2'd1);
    av0 = (q0.size() > 0) && !fl0;
    av1 = (q1.size() > 0) && !fl1;
    g = -1;
    if (av0 && av1) g = 1 - mlast;
    else if (av0)   g = 0;
    else if (av1)   g = 1;
    m_we   = 1'b0;
    m_done = 2'b00;
    if (g >= 0) begin
      if (g == 0) px = q0.pop_front();
      else        px = q1.pop_front();
      mlast = g;
      if (mptr[g] < FP) begin
        m_we   = 1'b1;
        m_addr = 16'(mptr[g] + g * FP);
        m_data = px;
        if (mptr[g] == FP - 1) m_done[g] = 1'b1;
        mptr[g]++;
      end
    end
    if (ovf_clr) movf = 2'b00;
    if (fl0) begin
      q0.delete(); mptr[0] = 0;
    end else if (ce0) begin
      if (q0.size() < DEPTH) q0.push_back(data0);
      else movf[0] = 1'b1;
    end
    if (fl1) begin
      q1.delete(); mptr[1] = 0;
    end else if (ce1) begin
      if (q1.size() < DEPTH) q1.push_back(data1);
      else movf[1] = 1'b1;
    end
  endtask

  // One clock: advance the model, take the edge, compare every output.
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    chk("fb_we", 32'(fb_we), 32'(m_we));
    chk("fb_addr", 32'(fb_addr), 32'(m_addr));
    chk("fb_data", 32'(fb_data), 32'(m_data));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("ovf", 32'(ovf), 32'(movf));
    if (fb_we) begin
      if (fb_addr < 16'(FP)) w0++;
      else                   w1++;
      if (verbose)
        $display("txn t=%0t addr=%0d data=%04h done=%b ovf=%b",
                 $time, fb_addr, fb_data, frame_done, ovf);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 32'(fb_we), 32'd0);
    chk({tag, "_addr"}, 32'(fb_addr), 32'd0);
    chk({tag, "_data"}, 32'(fb_data), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // Asserts reset between edges, checks outputs clear at once, then releases.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single stream: first write after E+1, consecutive addresses.
    ce0 = 1'b1; data0 = 15'h7FFF; step();
    chk("ss_first_we", 32'(fb_we), 32'd0);
    data0 = 15'h001F; step();
    chk("ss_w0_we", 32'(fb_we), 32'd1);
    chk("ss_w0_addr", 32'(fb_addr), 32'd0);
    chk("ss_w0_data", 32'(fb_data), 32'h7FFF);
    data0 = 15'h03E0; step();
    chk("ss_w1_addr", 32'(fb_addr), 32'd1);
    chk("ss_w1_data", 32'(fb_data), 32'h001F);
    ce0 = 1'b0; step();
    chk("ss_w2_addr", 32'(fb_addr), 32'd2);
    chk("ss_w2_data", 32'(fb_data), 32'h03E0);
    step();
    chk("ss_idle_we", 32'(fb_we), 32'd0);
    chk("ss_hold_addr", 32'(fb_addr), 32'd2);

    // Contention: both sources push every cycle.
    async_reset("rst_a");
    ce0 = 1'b1; ce1 = 1'b1; data0 = 15'h0AAA; data1 = 15'h0555;
    step();
    chk("ct_c1_we", 32'(fb_we), 32'd0);
    step();
    chk("ct_c2_addr", 32'(fb_addr), 32'd0);
    chk("ct_c2_data", 32'(fb_data), 32'h0AAA);
    step();
    chk("ct_c3_addr", 32'(fb_addr), 32'd23040);
    chk("ct_c3_data", 32'(fb_data), 32'h0555);
    for (int i = 4; i <= 7; i++) step();
    step();
    chk("ct_c8_ovf", 32'(ovf), 32'd2);
    step();
    chk("ct_c9_ovf", 32'(ovf), 32'd3);
    ovf_clr = 1'b1; step();
    chk("ct_clr_vs_set", 32'(ovf), 32'd2);
    ce0 = 1'b0; ce1 = 1'b0; step();
    chk("ct_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b0;
    w0 = 0; w1 = 0;
    for (int i = 0; i < 10; i++) step();
    chk("ct_drain_src0", 32'(w0), 32'(DEPTH));
    chk("ct_drain_src1", 32'(w1), 32'd3);

    // Flush mid-stream.
    async_reset("rst_b");
    ce0 = 1'b1; ce1 = 1'b1; data0 = 15'h1111; data1 = 15'h2222;
    for (int i = 0; i < 5; i++) step();
    on0 = 1'b0; ce1 = 1'b0; step();
    on0 = 1'b1; ce0 = 1'b0;
    w0 = 0;
    for (int i = 0; i < 6; i++) step();
    chk("fl_no_src0", 32'(w0), 32'd0);
    chk("fl_ovf", 32'(ovf), 32'd0);
    ce0 = 1'b1; data0 = 15'h1234; step();
    ce0 = 1'b0; step();
    chk("fl_re_we", 32'(fb_we), 32'd1);
    chk("fl_re_addr", 32'(fb_addr), 32'd0);
    chk("fl_re_data", 32'(fb_data), 32'h1234);

    // Frame wrap on source 1.
    async_reset("rst_c");
    verbose = 1'b0;
    ce1 = 1'b1;
    for (int i = 0; i < FP; i++) begin
      data1 = 15'(i);
      step();
    end
    ce1 = 1'b0; step();
    verbose = 1'b1;
    chk("fw_last_we", 32'(fb_we), 32'd1);
    chk("fw_last_addr", 32'(fb_addr), 32'd46079);
    chk("fw_last_data", 32'(fb_data), 32'h59FF);
    chk("fw_done", 32'(frame_done), 32'd2);
    ce1 = 1'b1; data1 = 15'h0123; step();
    ce1 = 1'b0; step();
    chk("fw_sat_we", 32'(fb_we), 32'd0);
    chk("fw_sat_done", 32'(frame_done), 32'd0);
    mode1 = 2'd1; step();
    mode1 = 2'd3; ce1 = 1'b1; data1 = 15'h4321; step();
    ce1 = 1'b0; step();
    chk("fw_new_we", 32'(fb_we), 32'd1);
    chk("fw_new_addr", 32'(fb_addr), 32'd23040);
    chk("fw_new_data", 32'(fb_data), 32'h4321);

    // Async reset in the middle of traffic, then the first tie goes to 0.
    ce0 = 1'b1; ce1 = 1'b1; data0 = 15'h0F0F; data1 = 15'h00F0;
    for (int i = 0; i < 3; i++) step();
    async_reset("rst_d");
    ce0 = 1'b1; ce1 = 1'b1; data0 = 15'h0F0F; data1 = 15'h00F0;
    step();
    chk("ar_c1_we", 32'(fb_we), 32'd0);
    ce0 = 1'b0; ce1 = 1'b0; step();
    chk("ar_tie_addr", 32'(fb_addr), 32'd0);
    chk("ar_tie_data", 32'(fb_data), 32'h0F0F);
    step();
    chk("ar_next_addr", 32'(fb_addr), 32'd23040);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
